// File: rtl/anunciador_alarma.sv
// Alarm annunciator: REPOSO / PREVENCION / ALERTA / SILENCIO with a tone divider and an alert counter.
// Latency: inputs sampled at one rising edge set every output right after that edge (one cycle).
// Backpressure: none; the inputs are levels evaluated every cycle and the outputs are always valid.
//
// Ports:
//   clk                - system clock, all state changes on the rising edge
//   rst                - synchronous, active-high reset
//   alarma_alerta      - alert-level alarm (level)
//   alarma_prevencion  - prevention-level alarm (level)
//   silenciar          - operator silence request; a held level counts once
//   buzzer             - registered audible drive
//   estado_codigo      - registered state: 00 REPOSO, 01 PREVENCION, 10 ALERTA, 11 SILENCIO
//   silenciado         - registered, high exactly while in SILENCIO
//   conteo_eventos     - registered saturating count of ALERTA entries
module anunciador_alarma #(
  parameter int PERIODO_ALERTA = 10,
  parameter int PERIODO_PREV   = 50,
  parameter int T_SILENCIO     = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarma_alerta,
  input  logic       alarma_prevencion,
  input  logic       silenciar,
  output logic       buzzer,
  output logic [1:0] estado_codigo,
  output logic       silenciado,
  output logic [7:0] conteo_eventos
);

  typedef enum logic [1:0] {
    REPOSO     = 2'b00,
    PREVENCION = 2'b01,
    ALERTA     = 2'b10,
    SILENCIO   = 2'b11
  } estado_t;

  localparam logic [7:0]  SEMI_ALERTA = 8'(PERIODO_ALERTA - 1);
  localparam logic [7:0]  SEMI_PREV   = 8'(PERIODO_PREV - 1);
  localparam logic [15:0] FIN_SIL     = 16'(T_SILENCIO - 1);

  estado_t     estado, estado_sig;
  logic        nivel_alerta, nivel_alerta_d;   // level that was silenced: 1 = ALERTA, 0 = PREVENCION
  logic        bloqueo_sil, bloqueo_sil_d;     // silenciar level already used or discarded
  logic [7:0]  divisor, divisor_d;
  logic [15:0] temporizador, temporizador_d;
  logic        buzzer_d, silenciado_d;
  logic [7:0]  conteo_d;

  logic pedido_sil;
  logic expira;
  logic entrada;

  // A request is only a silenciar level that has not yet been consumed.
  assign pedido_sil = silenciar & ~bloqueo_sil;
  assign expira     = (temporizador == FIN_SIL);
  assign entrada    = (estado_sig != estado);

  assign estado_codigo = estado;

  // State register (together with the registered outputs and datapath)
  always_ff @(posedge clk) begin
    if (rst) begin
      estado         <= REPOSO;
      nivel_alerta   <= 1'b0;
      bloqueo_sil    <= 1'b0;
      divisor        <= 8'd0;
      temporizador   <= 16'd0;
      buzzer         <= 1'b0;
      silenciado     <= 1'b0;
      conteo_eventos <= 8'd0;
    end else begin
      estado         <= estado_sig;
      nivel_alerta   <= nivel_alerta_d;
      bloqueo_sil    <= bloqueo_sil_d;
      divisor        <= divisor_d;
      temporizador   <= temporizador_d;
      buzzer         <= buzzer_d;
      silenciado     <= silenciado_d;
      conteo_eventos <= conteo_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO: begin
        if (alarma_alerta)          estado_sig = ALERTA;
        else if (alarma_prevencion) estado_sig = PREVENCION;
      end
      PREVENCION: begin
        if (alarma_alerta)           estado_sig = ALERTA;
        else if (pedido_sil)         estado_sig = SILENCIO;
        else if (!alarma_prevencion) estado_sig = REPOSO;
      end
      ALERTA: begin
        // Latching: only a silence request leaves ALERTA.
        if (pedido_sil) estado_sig = SILENCIO;
      end
      SILENCIO: begin
        if (!nivel_alerta && alarma_alerta)          estado_sig = ALERTA;
        else if (!alarma_alerta && !alarma_prevencion) estado_sig = REPOSO;
        else if (expira) begin
          if (alarma_alerta)          estado_sig = ALERTA;
          else if (alarma_prevencion) estado_sig = PREVENCION;
          else                        estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    buzzer_d       = 1'b0;
    divisor_d      = 8'd0;
    temporizador_d = 16'd0;
    nivel_alerta_d = nivel_alerta;
    silenciado_d   = (estado_sig == SILENCIO);
    conteo_d       = conteo_eventos;

    // Tone: restart high on every entry, then toggle each half-period.
    if (entrada) begin
      buzzer_d = (estado_sig == ALERTA) || (estado_sig == PREVENCION);
    end else if ((estado == ALERTA) || (estado == PREVENCION)) begin
      if (divisor == ((estado == ALERTA) ? SEMI_ALERTA : SEMI_PREV)) begin
        buzzer_d = ~buzzer;
      end else begin
        buzzer_d  = buzzer;
        divisor_d = divisor + 8'd1;
      end
    end

    if ((estado == SILENCIO) && !entrada) begin
      temporizador_d = temporizador + 16'd1;
    end

    if ((estado_sig == SILENCIO) && (estado != SILENCIO)) begin
      nivel_alerta_d = (estado == ALERTA);
    end

    if ((estado_sig == ALERTA) && (estado != ALERTA) && (conteo_eventos != 8'hFF)) begin
      conteo_d = conteo_eventos + 8'd1;
    end
  end

  // The silenciar level is marked used while it keeps high once it silenced,
  // was ignored in SILENCIO, or lost against a simultaneous alert; it must
  // drop for a cycle before it can request again.
  always_comb begin
    bloqueo_sil_d = silenciar &
                    (bloqueo_sil ||
                     (estado == SILENCIO) ||
                     (estado_sig == SILENCIO) ||
                     (alarma_alerta && ((estado == REPOSO) || (estado == PREVENCION))));
  end

endmodule
